// File: rtl/pe_job_sequencer.sv
// Initiator for one Processing_Element: clears it, streams A then B, runs the
// MAC phase with a timeout, reads the accumulator and returns it to the host.
module pe_job_sequencer #(
  parameter int N       = 16,
  parameter int TIMEOUT = 32
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic [1:0]  DIMEN_IN,
  input  logic        IN_VALID,
  input  logic [31:0] IN_DATA,
  output logic        IN_READY,
  output logic        RES_VALID,
  output logic [31:0] RES_DATA,
  output logic        RES_ERR,
  input  logic        RES_READY,
  output logic        BUSY,
  output logic        RST_ADD,
  output logic        RST_ACC,
  output logic        RST_PC,
  output logic        WRITE_MAT,
  output logic        MAT_MUX,
  output logic        MAC_CTRL,
  output logic        OUT_READY,
  output logic [1:0]  DIMEN,
  output logic [31:0] DATAIN,
  input  logic        MAC_DONE,
  input  logic [31:0] DATAOUT
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD_A,
    S_RADDR,
    S_LOAD_B,
    S_MAC,
    S_READ,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    dimen_q, dimen_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
  logic          res_valid_q, res_valid_d;
  logic [BW-1:0] len_m1;

  logic is_clr;
  logic is_load_a;
  logic is_raddr;
  logic is_load_b;
  logic is_mac;
  logic is_read;
  logic is_load;

  assign len_m1 = BW'((32'd2 << dimen_q) - 32'd1);

  assign is_clr    = (state_q == S_CLR);
  assign is_load_a = (state_q == S_LOAD_A);
  assign is_raddr  = (state_q == S_RADDR);
  assign is_load_b = (state_q == S_LOAD_B);
  assign is_mac    = (state_q == S_MAC);
  assign is_read   = (state_q == S_READ);
  assign is_load   = is_load_a | is_load_b;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    dimen_d     = dimen_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_CLR;
          dimen_d = DIMEN_IN;
        end
      end
      S_CLR: begin
        beat_d  = '0;
        state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        if (IN_VALID) begin
          if (beat_q == len_m1) begin
            beat_d  = '0;
            state_d = S_RADDR;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_RADDR: begin
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        if (IN_VALID) begin
          if (beat_q == len_m1) begin
            beat_d  = '0;
            tmo_d   = '0;
            state_d = S_MAC;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_MAC: begin
        tmo_d = tmo_q + TW'(1);
        // MAC_DONE wins over a timeout hitting in the same cycle
        if (MAC_DONE) begin
          tmo_d   = '0;
          state_d = S_READ;
        end else if (tmo_q == TLAST) begin
          tmo_d       = '0;
          res_data_d  = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_READ: begin
        res_data_d  = DATAOUT;
        res_err_d   = 1'b0;
        res_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      tmo_q       <= '0;
      dimen_q     <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      dimen_q     <= dimen_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  // PE strobes decode straight from the state register, so reset clears them at once
  assign RST_ADD   = is_clr | is_raddr;
  assign RST_ACC   = is_clr;
  assign RST_PC    = is_clr;
  assign WRITE_MAT = is_load & IN_VALID;
  assign MAT_MUX   = is_load_a;
  assign MAC_CTRL  = is_mac;
  assign OUT_READY = is_read;

  assign IN_READY  = is_load;
  assign BUSY      = (state_q != S_IDLE);
  assign DIMEN     = dimen_q;
  assign DATAIN    = IN_DATA;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_ERR   = res_err_q;

endmodule

// File: tb/tb_pe_job_sequencer.sv
// Bench for pe_job_sequencer with a behavioural PE model and a
// result scoreboard; table jobs plus reset, stall, timeout, hold cases.
module tb_pe_job_sequencer;
  localparam int N   = 16;
  localparam int TMO = 32;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        START = 1'b0;
  logic [1:0]  DIMEN_IN = 2'd0;
  logic        IN_VALID = 1'b0;
  logic [31:0] IN_DATA = 32'd0;
  logic        IN_READY;
  logic        RES_VALID;
  logic [31:0] RES_DATA;
  logic        RES_ERR;
  logic        RES_READY = 1'b1;
  logic        BUSY;
  logic        RST_ADD, RST_ACC, RST_PC;
  logic        WRITE_MAT, MAT_MUX, MAC_CTRL, OUT_READY;
  logic [1:0]  DIMEN;
  logic [31:0] DATAIN;
  logic        MAC_DONE;
  wire  [31:0] DATAOUT;

  pe_job_sequencer #(.N(N), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .DIMEN_IN(DIMEN_IN),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_ERR(RES_ERR),
    .RES_READY(RES_READY), .BUSY(BUSY),
    .RST_ADD(RST_ADD), .RST_ACC(RST_ACC), .RST_PC(RST_PC),
    .WRITE_MAT(WRITE_MAT), .MAT_MUX(MAT_MUX), .MAC_CTRL(MAC_CTRL),
    .OUT_READY(OUT_READY), .DIMEN(DIMEN), .DATAIN(DATAIN),
    .MAC_DONE(MAC_DONE), .DATAOUT(DATAOUT)
  );

  always #5 CLK = ~CLK;

  // Processing_Element model
  logic [31:0] pa [16];
  logic [31:0] pb [16];
  logic [4:0]  paddr = 5'd0;
  logic [4:0]  ppc = 5'd0;
  logic [31:0] pacc = 32'd0;
  logic [4:0]  plen;
  bit          stub = 1'b0;

  assign plen     = 5'd2 << DIMEN;
  assign MAC_DONE = !stub && (ppc == plen - 5'd1);
  assign DATAOUT  = OUT_READY ? pacc : 32'bz;

  always @(posedge CLK) begin
    if (RST_ADD) paddr <= 5'd0;
    else if (WRITE_MAT) begin
      if (MAT_MUX) pa[paddr[3:0]] <= DATAIN;
      else pb[paddr[3:0]] <= DATAIN;
      paddr <= paddr + 5'd1;
    end
    if (RST_PC) ppc <= 5'd0;
    else if (MAC_CTRL) ppc <= ppc + 5'd1;
    if (RST_ACC) pacc <= 32'd0;
    else if (MAC_CTRL) pacc <= pacc + pa[ppc[3:0]] * pb[ppc[3:0]];
  end

  // protocol monitor
  logic [6:0]  pe_ctl;
  int          wm_n = 0, wma_n = 0, mac_n = 0, viol_n = 0;
  logic        prev_hold = 1'b0, prev_err = 1'b0, seen_b = 1'b0;
  logic [31:0] prev_data = 32'd0;

  assign pe_ctl = {RST_ADD, RST_ACC, RST_PC, WRITE_MAT, MAT_MUX, MAC_CTRL, OUT_READY};

  always @(negedge CLK) begin
    wm_n  <= wm_n + (WRITE_MAT ? 1 : 0);
    wma_n <= wma_n + ((WRITE_MAT && MAT_MUX) ? 1 : 0);
    mac_n <= mac_n + (MAC_CTRL ? 1 : 0);
    viol_n <= viol_n
      + ((WRITE_MAT && (RST_ADD || !IN_VALID)) ? 1 : 0)
      + (((!BUSY || RES_VALID) && pe_ctl != 7'd0) ? 1 : 0)
      + ((WRITE_MAT && MAT_MUX && seen_b) ? 1 : 0)
      + ((prev_hold && (!RES_VALID || RES_DATA != prev_data
          || RES_ERR != prev_err)) ? 1 : 0);
    if (RST_ACC) seen_b <= 1'b0;
    else if (WRITE_MAT && !MAT_MUX) seen_b <= 1'b1;
    prev_hold <= RSTN && RES_VALID && !RES_READY;
    prev_data <= RES_DATA;
    prev_err  <= RES_ERR;
  end

  typedef struct {
    logic [1:0]        dim;
    bit                stall;
    logic [15:0][31:0] a;
    logic [15:0][31:0] b;
    logic [31:0]       exp;
    int                lat;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  vec_t        tbl [4];
  exp_t        sb_q [$];
  logic [31:0] va [16];
  logic [31:0] vb [16];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic load_vec(input int t);
    for (int i = 0; i < 16; i++) begin
      va[i] = tbl[t].a[i];
      vb[i] = tbl[t].b[i];
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 64'({IN_READY, RES_VALID, RES_ERR, BUSY, pe_ctl, DIMEN}), 64'd0);
    chk({nm, "_data"}, 64'(RES_DATA), 64'd0);
  endtask

  // Starts at posedge+1 with the DUT idle; ends at posedge+1 after the handshake.
  task automatic run_job(input string nm, input logic [1:0] dim, input bit stall,
                         input int hold, input logic [31:0] exp_data, input bit exp_err,
                         input int exp_lat, input int exp_mac, input int abort_beat);
    int   len, edges, beat, lat, hcnt, k, guard;
    int   wm0, wma0, mac0, viol0;
    bit   acc, hs, done;
    exp_t e;
    len  = 2 << dim;
    wm0  = wm_n;
    wma0 = wma_n;
    mac0 = mac_n;
    viol0 = viol_n;
    START = 1'b1;
    DIMEN_IN = dim;
    if (abort_beat < 0) begin
      e.data = exp_data;
      e.err  = exp_err;
      sb_q.push_back(e);
    end
    @(posedge CLK); #1;
    START = 1'b0;
    // latency counts the START-sampling edge as edge 1
    edges = 1; beat = 0; lat = 0; hcnt = 0; k = 0; guard = 0; done = 1'b0;
    while (!done && guard < 500) begin
      guard++;
      if (RES_VALID && lat == 0) lat = edges;
      if (beat < 2 * len) begin
        IN_VALID = stall ? (k % 3 == 0) : 1'b1;
        IN_DATA  = !IN_VALID ? 32'hDEAD_BEEF : (beat < len ? va[beat] : vb[beat - len]);
        k++;
      end else begin
        IN_VALID = 1'b0;
        IN_DATA  = 32'd0;
      end
      if (RES_VALID && hcnt < hold) begin
        RES_READY = 1'b0;
        START = (hcnt % 2 == 0);
        hcnt++;
      end else begin
        RES_READY = 1'b1;
        START = (hold > 0) && RES_VALID;
      end
      if (abort_beat >= 0 && beat == abort_beat) begin
        chk({nm, "_busy_pre"}, 64'(BUSY), 64'd1);
        #2 RSTN = 1'b0;
        #1 chk_zero({nm, "_rst"});
        IN_VALID = 1'b0;
        @(posedge CLK); #3;
        RSTN = 1'b1;
        return;
      end
      acc = IN_VALID && IN_READY;
      hs  = RES_VALID && RES_READY;
      if (hs) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL %s_sb got=result exp=none", nm);
        end else begin
          e = sb_q.pop_front();
          chk({nm, "_data"}, 64'(RES_DATA), 64'(e.data));
          chk({nm, "_err"}, 64'(RES_ERR), 64'(e.err));
        end
      end
      @(posedge CLK); #1;
      edges++;
      if (acc) beat++;
      if (hs) done = 1'b1;
    end
    START = 1'b0;
    IN_VALID = 1'b0;
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_idle"}, 64'(BUSY), 64'd0);
    if (exp_lat > 0) chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_wm"}, 64'(wm_n - wm0), 64'(2 * len));
    chk({nm, "_wma"}, 64'(wma_n - wma0), 64'(len));
    chk({nm, "_mac"}, 64'(mac_n - mac0), 64'(exp_mac));
    chk({nm, "_viol"}, 64'(viol_n - viol0), 64'd0);
  endtask

  initial begin
    for (int t = 0; t < 4; t++) begin
      tbl[t].a = '0;
      tbl[t].b = '0;
    end
    tbl[0].dim = 2'd0; tbl[0].stall = 1'b0; tbl[0].exp = 32'd39; tbl[0].lat = 10;
    tbl[0].a[0] = 32'd3; tbl[0].a[1] = 32'd4;
    tbl[0].b[0] = 32'd5; tbl[0].b[1] = 32'd6;
    tbl[1].dim = 2'd3; tbl[1].stall = 1'b0; tbl[1].exp = 32'd136; tbl[1].lat = 52;
    for (int i = 0; i < 16; i++) begin
      tbl[1].a[i] = 32'(i + 1);
      tbl[1].b[i] = 32'd1;
    end
    tbl[2].dim = 2'd1; tbl[2].stall = 1'b1; tbl[2].exp = 32'd20; tbl[2].lat = 0;
    for (int i = 0; i < 4; i++) begin
      tbl[2].a[i] = 32'(i + 1);
      tbl[2].b[i] = 32'(4 - i);
    end
    // sum of -(i+1)(i+2) over i=0..7 is -240, wrapping mod 2^32
    tbl[3].dim = 2'd2; tbl[3].stall = 1'b0; tbl[3].exp = 32'hFFFF_FF10; tbl[3].lat = 28;
    for (int i = 0; i < 8; i++) begin
      tbl[3].a[i] = 32'hFFFF_FFFF - 32'(i);
      tbl[3].b[i] = 32'(i + 2);
    end

    repeat (2) @(posedge CLK);
    #1 chk_zero("reset");
    @(posedge CLK); #3;
    RSTN = 1'b1;
    @(posedge CLK); #1;

    for (int t = 0; t < 4; t++) begin
      load_vec(t);
      run_job($sformatf("job%0d", t), tbl[t].dim, tbl[t].stall, 0, tbl[t].exp,
              1'b0, tbl[t].lat, 2 << tbl[t].dim, -1);
    end

    load_vec(0);
    run_job("hold", 2'd0, 1'b0, 5, 32'd39, 1'b0, 10, 2, -1);

    stub = 1'b1;
    run_job("tmo", 2'd0, 1'b0, 0, 32'd0, 1'b1, 4 + TMO + 3, TMO, -1);
    stub = 1'b0;

    run_job("abort", 2'd0, 1'b0, 0, 32'd0, 1'b0, 0, 0, 3);
    run_job("after_rst", 2'd0, 1'b0, 0, 32'd39, 1'b0, 10, 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
